// File: rtl/chunk_adder.sv
// chunk_adder
// -----------------------------------------------------------------------------
// Multi-cycle WIDTH-bit add / subtract / increment / decrement. One SLICE-bit
// slice is summed per clock, LSB slice first, with the inter-slice carry held
// in a register so the combinational path is a single SLICE-bit ripple.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   SLICE  bits summed per clock; must divide WIDTH evenly
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; accepted only on an edge where busy = 0
//   A, B   operands, latched on accept
//   CODE   operation, latched on accept:
//            0 signed add    1 unsigned add   2 signed sub   3 unsigned sub
//            4 signed inc    5 signed dec     6/7 reserved (C = A)
//   cin    carry in, latched on accept (a true difference needs cin = 1)
//   coe    carry-out enable, active low, latched on accept
//   busy   high while an operation is held (RUN or DONE)
//   done   one-cycle completion pulse
//   C      result, held until the next completion
//   vout   signed overflow (codes 0, 2, 4, 5 only)
//   cout   carry out of the MSB, forced to 0 when coe was 1
//
// Build option
//   CHUNK_ADDER_SATURATE_EN  when defined, a signed overflow clamps C to the
//                            max positive / min negative value according to
//                            A[MSB]; vout and cout are reported unchanged.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module chunk_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       CODE,
  input  logic             cin,
  input  logic             coe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             vout,
  output logic             cout
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB    = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic [2:0]       code_q;
  logic             coe_q, carry_q;
  logic [CW-1:0]    cnt;

  logic             accept, last, signed_op;
  logic [WIDTH-1:0] b_eff;
  logic             k_eff;
  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic             c_sl;
  logic [WIDTH-1:0] sum_full, c_res;
  logic             v_res;

  assign accept = start && (state == IDLE);
  assign last   = (cnt == CW'(NSLICE - 1));

  // Effective operand B' and initial carry k, decoded from the live inputs
  // so only the decoded values need latching on accept.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    b_eff = '0;
    k_eff = 1'b0;
    case (CODE)
      3'd0, 3'd1: begin b_eff = B;    k_eff = cin;  end
      3'd2, 3'd3: begin b_eff = ~B;   k_eff = cin;  end
      3'd4:       begin b_eff = '0;   k_eff = 1'b1; end
      3'd5:       begin b_eff = '1;   k_eff = 1'b0; end
      default:    begin b_eff = '0;   k_eff = 1'b0; end
    endcase
  end

  // One slice of ripple-carry per clock.
  always_comb begin
    a_sl = a_q[int'(cnt)*SLICE +: SLICE];
    b_sl = b_q[int'(cnt)*SLICE +: SLICE];
    {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    // Full sum with the slice being computed this cycle merged in; only
    // meaningful on the last slice, when it becomes the result.
    sum_full = acc;
    sum_full[int'(cnt)*SLICE +: SLICE] = s_sl;
  end

  always_comb begin
    signed_op = 1'b0;
    case (code_q)
      3'd0, 3'd2, 3'd4, 3'd5: signed_op = 1'b1;
      default:                signed_op = 1'b0;
    endcase
  end

  assign v_res = signed_op && (a_q[MSB] == b_q[MSB]) && (sum_full[MSB] != a_q[MSB]);

`ifdef CHUNK_ADDER_SATURATE_EN
  // Overflow can only occur when A and B' share a sign, so A[MSB] picks the
  // rail the true result ran past.
  always_comb begin
    c_res = sum_full;
    if (v_res)
      c_res = a_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
  end
`else
  assign c_res = sum_full;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath and registered outputs. busy/done are registered from the
  // next state so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand/accumulator registers are reset along with the
    // control flops; the block is small and an abort must leave no stale
    // partial sum behind.
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      C       <= '0;
      vout    <= 1'b0;
      cout    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      code_q  <= '0;
      coe_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values regardless of statement order.
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= b_eff;
            carry_q <= k_eff;
            code_q  <= CODE;
            coe_q   <= coe;
            cnt     <= '0;
          end
        end
        RUN: begin
          acc     <= sum_full;
          carry_q <= c_sl;
          cnt     <= cnt + CW'(1);
          if (last) begin
            C    <= c_res;
            vout <= v_res;
            cout <= ~coe_q & c_sl;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_adder.sv
`timescale 1ns/1ps

module tb_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main DUT: WIDTH=16, SLICE=4
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [2:0]  CODE = '0;
  logic        cin = 1'b0, coe = 1'b0;
  logic        busy, done, vout, cout;
  logic [15:0] C;

  // WIDTH=32, SLICE=8
  logic        start_w = 1'b0;
  logic [31:0] a_w = '0, b_w = '0;
  logic [2:0]  code_w = '0;
  logic        cin_w = 1'b0, coe_w = 1'b0;
  logic        busy_w, done_w, vout_w, cout_w;
  logic [31:0] c_w;

  // WIDTH=16, SLICE=16
  logic        start_s = 1'b0;
  logic [15:0] a_s = '0, b_s = '0;
  logic [2:0]  code_s = '0;
  logic        cin_s = 1'b0, coe_s = 1'b0;
  logic        busy_s, done_s, vout_s, cout_s;
  logic [15:0] c_s;

  chunk_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .CODE(CODE),
    .cin(cin), .coe(coe), .busy(busy), .done(done), .C(C), .vout(vout), .cout(cout)
  );

  chunk_adder #(.WIDTH(32), .SLICE(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .A(a_w), .B(b_w), .CODE(code_w),
    .cin(cin_w), .coe(coe_w), .busy(busy_w), .done(done_w), .C(c_w), .vout(vout_w), .cout(cout_w)
  );

  chunk_adder #(.WIDTH(16), .SLICE(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .A(a_s), .B(b_s), .CODE(code_s),
    .cin(cin_s), .coe(coe_s), .busy(busy_s), .done(done_s), .C(c_s), .vout(vout_s), .cout(cout_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  code;
    logic [15:0] a, b;
    logic        cin, coe;
    logic [15:0] c, c_sat;
    logic        v, co;
  } vec_t;

  vec_t vecs[13];

  // Accept one operation on the main DUT, scramble the inputs right after
  // accept, and wait (bounded) for done. lat = edges from accept to done.
  task automatic op16(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic ce, output int lat);
    int n;
    @(negedge clk);
    start = 1'b1; CODE = code; A = a; B = b; cin = ci; coe = ce;
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); CODE = 3'($urandom);
    cin = 1'($urandom); coe = 1'($urandom);
    check("busy_after_accept", busy, 1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  initial begin
    int lat, t, t1, gap;
    logic seen;

    vecs[0]  = '{3'd0, 16'h7F00, 16'h0300, 1'b0, 1'b0, 16'h8200, 16'h7FFF, 1'b1, 1'b0};
    vecs[1]  = '{3'd1, 16'hFF00, 16'h0100, 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b1};
    vecs[2]  = '{3'd1, 16'hFF00, 16'h0100, 1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[3]  = '{3'd2, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 16'h0002, 1'b0, 1'b1};
    vecs[5]  = '{3'd4, 16'h7FFF, 16'h1234, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0};
    vecs[6]  = '{3'd5, 16'h8000, 16'h0000, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vecs[7]  = '{3'd6, 16'h1234, 16'hFFFF, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[8]  = '{3'd7, 16'hABCD, 16'h5555, 1'b1, 1'b0, 16'hABCD, 16'hABCD, 1'b0, 1'b0};
    vecs[9]  = '{3'd0, 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 16'h2346, 1'b0, 1'b0};
    vecs[10] = '{3'd0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
    vecs[11] = '{3'd1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{3'd2, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1};

    // Reset state
    #7;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_c",    C,    0);
    check("rst_vout", vout, 0);
    check("rst_cout", cout, 0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      op16(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].coe, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 4);
      check($sformatf("v%0d_done", i), done, 1);
`ifdef CHUNK_ADDER_SATURATE_EN
      check($sformatf("v%0d_c", i), C, vecs[i].c_sat);
`else
      check($sformatf("v%0d_c", i), C, vecs[i].c);
`endif
      check($sformatf("v%0d_vout", i), vout, vecs[i].v);
      check($sformatf("v%0d_cout", i), cout, vecs[i].co);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_fall", i), done, 0);
      check($sformatf("v%0d_busy_fall", i), busy, 0);
    end

    // start held high: accepts every 6 cycles, C holds between done pulses,
    // and start during DONE is ignored.
    @(negedge clk);
    start = 1'b1; CODE = 3'd1; A = 16'h0001; B = 16'h0001; cin = 1'b0; coe = 1'b0;
    t = 0; t1 = 0; seen = 1'b0;
    while (!seen && t < 20) begin
      @(posedge clk); #1; t++;
      if (done) seen = 1'b1;
    end
    check("hold_first_done", seen, 1);
    check("hold_first_c", C, 16'h0002);
    t1 = t;
    A = 16'h0010;
    seen = 1'b0;
    while (!seen && t < 40) begin
      @(posedge clk); #1; t++;
      if (done) seen = 1'b1;
      else check("hold_c_stable", C, 16'h0002);
    end
    gap = t - t1;
    check("hold_second_done", seen, 1);
    check("hold_gap", 64'(gap), 6);
    check("hold_second_c", C, 16'h0011);
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);

    // Reset after two RUN edges aborts: outputs to 0, no done.
    @(negedge clk);
    start = 1'b1; CODE = 3'd0; A = 16'h1111; B = 16'h2222; cin = 1'b0; coe = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_c",    C,    0);
    check("abort_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    op16(3'd0, 16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    check("post_abort_latency", 64'(lat), 4);
    check("post_abort_c", C, 16'h3333);
    @(posedge clk); #1;

    // WIDTH=32, SLICE=8: four RUN edges
    @(negedge clk);
    start_w = 1'b1; code_w = 3'd1; a_w = 32'h0000FFFF; b_w = 32'h00000001; cin_w = 1'b0; coe_w = 1'b0;
    @(posedge clk); #1;
    start_w = 1'b0; a_w = 32'hDEADBEEF; b_w = 32'h12345678;
    t = 0;
    while (!done_w && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("w32_latency", 64'(t), 4);
    check("w32_c",    c_w,    32'h00010000);
    check("w32_vout", vout_w, 0);
    check("w32_cout", cout_w, 0);

    // WIDTH=16, SLICE=16: one RUN edge
    @(negedge clk);
    start_s = 1'b1; code_s = 3'd0; a_s = 16'h7F00; b_s = 16'h0300; cin_s = 1'b0; coe_s = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b0; a_s = 16'h0000; b_s = 16'h0000;
    t = 0;
    while (!done_s && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("s16_latency", 64'(t), 1);
`ifdef CHUNK_ADDER_SATURATE_EN
    check("s16_c", c_s, 16'h7FFF);
`else
    check("s16_c", c_s, 16'h8200);
`endif
    check("s16_vout", vout_s, 1);
    check("s16_cout", cout_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
